lcd_octal_streamer: RTL
=======================

LCD_OCTAL_STREAMER -- requirements
Module: lcd_octal_streamer

Interface
REQ-001 SETUP_CYC, default 1: cycles lcd_data/lcd_rs are driven with lcd_en low before each enable pulse.
REQ-002 EN_HIGH_CYC, default 4: width of each lcd_en pulse, in cycles.
REQ-003 HOLD_CYC, default 40: cycles lcd_en stays low after each pulse before the next write, covering the LCD execution time.
REQ-004 clk  input  1  single system clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  request to display data_in; sampled only in IDLE.
REQ-007 data_in  input  18  bus word to display; captured when start is accepted.
REQ-008 line_sel  input  1  target line (0 = line 1, 1 = line 2); captured with data_in.
REQ-009 busy  output  1  high while a transfer is in progress.
REQ-010 done  output  1  one-cycle pulse when a transfer completes.
REQ-011 lcd_data  output  8  LCD command/character byte.
REQ-012 lcd_rs  output  1  register select (0 = command, 1 = data).
REQ-013 lcd_rw  output  1  read/write select; tied to 0 (write only).
REQ-014 lcd_en  output  1  LCD enable strobe.

Function
REQ-015 States SHALL be IDLE, SETUP, PULSE, HOLD and DONE, with a write index idx in 0..6.
REQ-016 In IDLE, start=1 at a rising edge SHALL capture data_in and line_sel, set idx=0, enter SETUP and assert busy from the next cycle.
REQ-017 start SHALL be ignored in every state except IDLE; captured data SHALL not change during a transfer.
REQ-018 Write idx=0 SHALL be a command: lcd_rs=0; lcd_data=0x80 when line_sel=0, 0xC0 when line_sel=1.
REQ-019 Writes idx=1..6 SHALL be characters with lcd_rs=1.
REQ-020 Character byte SHALL be 0x30 + octal digit d, where d = data[20-3*idx : 18-3*idx], most significant digit first.
REQ-021 Character values SHALL lie in the range 0x30..0x37 only.
REQ-022 SETUP SHALL last SETUP_CYC cycles with lcd_en=0, then go to PULSE.
REQ-023 PULSE SHALL last EN_HIGH_CYC cycles with lcd_en=1, then go to HOLD.
REQ-024 HOLD SHALL last HOLD_CYC cycles with lcd_en=0.
REQ-025 On leaving HOLD: if idx<6, idx SHALL increment and the state SHALL return to SETUP; if idx=6, go to DONE.
REQ-026 lcd_data and lcd_rs SHALL stay constant from the start of SETUP to the end of HOLD of each write.
REQ-027 lcd_en SHALL be a registered output, free of glitches.
REQ-028 DONE SHALL last exactly one cycle with done=1 and busy=1, then return to IDLE with busy=0.
REQ-029 Latency: the start edge is edge N; done SHALL be high in the cycle after edge N+7*(SETUP_CYC+EN_HIGH_CYC+HOLD_CYC); with defaults, done is high in cycle N+316.
REQ-030 Any parameter set to 0 SHALL behave as 1.
REQ-031 Phase counters SHALL be sized for values up to 2^16-1.
REQ-032 In IDLE, lcd_en SHALL be 0 and lcd_data/lcd_rs SHALL hold the last written values.

Reset
REQ-033 reset=0 SHALL immediately, without waiting for clk, force: state IDLE, idx=0, busy=0, done=0, lcd_en=0, lcd_rs=0, lcd_rw=0, lcd_data=0x00, captured data=0.
REQ-034 Reset asserted mid-transfer SHALL abort the transfer with no done pulse.
REQ-035 After reset release, the first rising edge SHALL be an ordinary IDLE cycle; start on that edge SHALL be accepted.

Verification
REQ-036 data_in=18'o123456, line_sel=0, defaults -> writes 0x80 (rs=0), then 0x31,0x32,0x33,0x34,0x35,0x36 (rs=1); done is a single pulse in cycle N+316; busy is 0 afterwards.
REQ-037 data_in=18'o777777, line_sel=1 -> 0xC0, then six 0x37.
REQ-038 data_in=0, line_sel=0 -> 0x80, then six 0x30.
REQ-039 start re-pulsed with data_in=18'o000001 at cycle N+50 -> ignored; output matches the first capture; exactly one done pulse.
REQ-040 Timing check on every write -> lcd_en high for exactly EN_HIGH_CYC cycles; at least SETUP_CYC cycles before and HOLD_CYC cycles after with lcd_en low; lcd_data/lcd_rs stable across the write; lcd_rw always 0.
REQ-041 reset=0 asserted during PULSE of the 3rd write -> lcd_en, busy and lcd_data go to 0 before the next edge; no done pulse; after release, a new start with 18'o000777 produces the complete 7-write sequence.

Source files
------------

// File: rtl/lcd_octal_streamer.sv
// ---------------------------------------------------------------------------
// lcd_octal_streamer
//
// Streams an 18-bit bus word to an HD44780-style character LCD as six octal
// digits. Each transfer is seven LCD writes: one "set DDRAM address" command
// selecting the start of line 1 or line 2, then six ASCII characters '0'..'7',
// most significant digit first.
//
// Every write uses the same three-phase bus cycle:
//   SETUP : lcd_data/lcd_rs valid, lcd_en low   (SETUP_CYC cycles)
//   PULSE : lcd_en high                          (EN_HIGH_CYC cycles)
//   HOLD  : lcd_en low, LCD executes the write   (HOLD_CYC cycles)
// A parameter of 0 is treated as 1, so every phase lasts at least one cycle.
//
// Ports
//   clk       in   1   system clock, rising edge
//   reset     in   1   asynchronous, active-low reset
//   start     in   1   request a transfer; only sampled while idle
//   data_in   in  18   word to display, captured on the accepted start
//   line_sel  in   1   0 = line 1 (cmd 0x80), 1 = line 2 (cmd 0xC0)
//   busy      out  1   high from the cycle after start until the done cycle
//   done      out  1   one-cycle pulse at the end of a transfer
//   lcd_data  out  8   command / character byte
//   lcd_rs    out  1   0 = command, 1 = character data
//   lcd_rw    out  1   always 0, the LCD is only written
//   lcd_en    out  1   enable strobe, driven straight from a flop
// ---------------------------------------------------------------------------
module lcd_octal_streamer #(
    parameter int unsigned SETUP_CYC   = 1,
    parameter int unsigned EN_HIGH_CYC = 4,
    parameter int unsigned HOLD_CYC    = 40
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [17:0] data_in,
    input  logic        line_sel,
    output logic        busy,
    output logic        done,
    output logic [7:0]  lcd_data,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic        lcd_en
);

    // Terminal value of the 16-bit phase counter for a phase of 'cyc' cycles.
    // Zero is promoted to one and oversized values saturate at 2^16-1 cycles.
    function automatic logic [15:0] last_count(input int unsigned cyc);
        int unsigned c;
        c = (cyc == 0) ? 1 : cyc;
        if (c > 65535) begin
            c = 65535;
        end
        return 16'(c - 1);
    endfunction

    localparam logic [15:0] SETUP_LAST = last_count(SETUP_CYC);
    localparam logic [15:0] EN_LAST    = last_count(EN_HIGH_CYC);
    localparam logic [15:0] HOLD_LAST  = last_count(HOLD_CYC);

    localparam logic [2:0] LAST_IDX = 3'd6;

    localparam logic [7:0] CMD_LINE1 = 8'h80;
    localparam logic [7:0] CMD_LINE2 = 8'hC0;

    // ASCII character for write idx (1..6); idx 1 carries the top octal digit.
    function automatic logic [7:0] char_byte(input logic [2:0] idx,
                                             input logic [17:0] word);
        logic [2:0] digit;
        case (idx)
            3'd1:    digit = word[17:15];
            3'd2:    digit = word[14:12];
            3'd3:    digit = word[11:9];
            3'd4:    digit = word[8:6];
            3'd5:    digit = word[5:3];
            default: digit = word[2:0];
        endcase
        // 0x30 + digit; the digit is 3 bits so the result stays in 0x30..0x37.
        return {5'b00110, digit};
    endfunction

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StPulse,
        StHold,
        StDone
    } state_e;

    state_e      state_q;
    logic [2:0]  idx_q;
    logic [15:0] cnt_q;
    logic [17:0] data_q;
    logic [2:0]  idx_next;

    assign idx_next = 3'(idx_q + 3'd1);

    // The bus is write-only.
    assign lcd_rw = 1'b0;

    // Single FSM block; every output except lcd_rw comes from a flop, so
    // lcd_en cannot glitch. lcd_data/lcd_rs are only loaded on entry to SETUP,
    // which keeps them constant through SETUP, PULSE and HOLD of each write and
    // leaves the last written byte on the bus while idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            idx_q    <= 3'd0;
            cnt_q    <= 16'd0;
            data_q   <= 18'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            lcd_data <= 8'h00;
            lcd_rs   <= 1'b0;
            lcd_en   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    lcd_en <= 1'b0;
                    if (start) begin
                        data_q   <= data_in;
                        idx_q    <= 3'd0;
                        cnt_q    <= 16'd0;
                        busy     <= 1'b1;
                        lcd_data <= line_sel ? CMD_LINE2 : CMD_LINE1;
                        lcd_rs   <= 1'b0;
                        state_q  <= StSetup;
                    end
                end

                StSetup: begin
                    if (cnt_q == SETUP_LAST) begin
                        cnt_q   <= 16'd0;
                        lcd_en  <= 1'b1;
                        state_q <= StPulse;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end

                StPulse: begin
                    if (cnt_q == EN_LAST) begin
                        cnt_q   <= 16'd0;
                        lcd_en  <= 1'b0;
                        state_q <= StHold;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end

                StHold: begin
                    if (cnt_q == HOLD_LAST) begin
                        cnt_q <= 16'd0;
                        if (idx_q == LAST_IDX) begin
                            done    <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            idx_q    <= idx_next;
                            lcd_data <= char_byte(idx_next, data_q);
                            lcd_rs   <= 1'b1;
                            state_q  <= StSetup;
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end

                StDone: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end

                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    lcd_en  <= 1'b0;
                end
            endcase
        end
    end

endmodule
